plugboard_cfg_ctrl: RTL and testbench

Programmable plugboard for the Enigma datapath. It holds the letter-swap table as registered state and accepts PAIR, UNPAIR and CLEAR commands over a valid/ready handshake, checking each command before it applies it. It drives a one-hot 26-bit signal through the table in the same way as the fixed plugboard stage. It sits between the key-setup logic and the rotor path, and replaces the hard-wired swap with a runtime-configurable one.

---
 rtl/plugboard_cfg_ctrl.sv | 171 +++++++++++++++++
 tb/tb_plugboard_cfg_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/plugboard_cfg_ctrl.sv
// plugboard_cfg_ctrl: runtime-programmable Enigma plugboard.
// Holds an involutive 26-entry letter-swap table and updates it through
// PAIR / UNPAIR / CLEAR commands. Each command is checked before it is applied.
// The current table routes a one-hot letter combinationally from sig_in to sig_out.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is high only in IDLE. cmd_op/cmd_a/cmd_b are sampled only on that edge.
// Exactly one rsp_valid pulse follows each accepted command, unless reset aborts it.
module plugboard_cfg_ctrl #(
  parameter int MAX_PAIRS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_a,
  input  logic [4:0]  cmd_b,
  output logic        rsp_valid,
  output logic [1:0]  rsp_code,
  output logic        rsp_err,
  output logic [3:0]  pair_count,
  output logic        cfg_stable,
  input  logic [25:0] sig_in,
  output logic [25:0] sig_out,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, CLR = 2'd2, RESP = 2'd3} state_t;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_PAIR   = 2'b01;
  localparam logic [1:0] OP_UNPAIR = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  localparam logic [1:0] RC_OK       = 2'b00;
  localparam logic [1:0] RC_BAD      = 2'b01;
  localparam logic [1:0] RC_CONFLICT = 2'b10;
  localparam logic [1:0] RC_FULL     = 2'b11;

  localparam logic [3:0] MAX_P  = 4'(MAX_PAIRS);
  localparam logic [4:0] LAST_L = 5'd25;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  a_q, a_d;
  logic [4:0]  b_q, b_d;
  logic [4:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  map_q [26];
  logic [4:0]  map_d [26];
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_code_q, rsp_code_d;

  logic        a_in, b_in;
  logic [4:0]  map_a, map_b;
  logic [1:0]  code;

  // Look up the latched letters. Out-of-range letters never reach the table.
  always_comb begin
    a_in  = (a_q <= LAST_L);
    b_in  = (b_q <= LAST_L);
    map_a = a_in ? map_q[a_q] : a_q;
    map_b = b_in ? map_q[b_q] : b_q;
    code  = RC_OK;
    case (op_q)
      OP_PAIR: begin
        if (!a_in || !b_in || (a_q == b_q))       code = RC_BAD;
        else if ((map_a != a_q) || (map_b != b_q)) code = RC_CONFLICT;
        else if (cnt_q >= MAX_P)                   code = RC_FULL;
      end
      OP_UNPAIR: begin
        if (!a_in)               code = RC_BAD;
        else if (map_a == a_q)   code = RC_CONFLICT;
      end
      default: code = RC_OK;
    endcase
  end

  // Next-state logic for the FSM, the table and the response registers.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    map_d       = map_q;
    rsp_valid_d = 1'b0;
    rsp_code_d  = rsp_code_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          a_d     = cmd_a;
          b_d     = cmd_b;
          idx_d   = 5'd0;
          state_d = (cmd_op == OP_CLEAR) ? CLR : EXEC;
        end
      end
      EXEC: begin
        if (code == RC_OK) begin
          if (op_q == OP_PAIR) begin
            map_d[a_q] = b_q;
            map_d[b_q] = a_q;
            cnt_d      = cnt_q + 4'd1;
          end else if (op_q == OP_UNPAIR) begin
            map_d[a_q]   = a_q;
            map_d[map_a] = map_a;
            cnt_d        = cnt_q - 4'd1;
          end
        end
        rsp_valid_d = 1'b1;
        rsp_code_d  = code;
        state_d     = RESP;
      end
      CLR: begin
        map_d[idx_q] = idx_q;
        idx_d        = idx_q + 5'd1;
        if (idx_q == LAST_L) begin
          cnt_d       = 4'd0;
          rsp_valid_d = 1'b1;
          rsp_code_d  = RC_OK;
          state_d     = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset restores the identity table and drops any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_NOP;
      a_q         <= 5'd0;
      b_q         <= 5'd0;
      idx_q       <= 5'd0;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_code_q  <= RC_OK;
      for (int i = 0; i < 26; i++) map_q[i] <= 5'(i);
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_code_q  <= rsp_code_d;
      map_q       <= map_d;
    end
  end

  // Route the one-hot letter through the table: output j takes input map[j].
  always_comb begin
    sig_out = '0;
    for (int j = 0; j < 26; j++) sig_out[j] = sig_in[map_q[j]];
  end

  assign cmd_ready  = (state_q == IDLE);
  assign cfg_stable = (state_q == IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_code   = rsp_code_q;
  assign rsp_err    = (rsp_code_q != RC_OK);
  assign pair_count = cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_plugboard_cfg_ctrl.sv
// Testbench for plugboard_cfg_ctrl: a reference table model plus a response scoreboard.
module tb_plugboard_cfg_ctrl;

  localparam logic [1:0] OP_NOP = 2'b00, OP_PAIR = 2'b01, OP_UNPAIR = 2'b10, OP_CLEAR = 2'b11;
  localparam logic [1:0] RC_OK = 2'b00, RC_BAD = 2'b01, RC_CONFLICT = 2'b10, RC_FULL = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_a, cmd_b;
  logic        rsp_valid, rsp_err, cfg_stable;
  logic [1:0]  rsp_code, dbg_state;
  logic [3:0]  pair_count;
  logic [25:0] sig_in, sig_out;

  plugboard_cfg_ctrl #(.MAX_PAIRS(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_code(rsp_code), .rsp_err(rsp_err),
    .pair_count(pair_count), .cfg_stable(cfg_stable),
    .sig_in(sig_in), .sig_out(sig_out), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_q[$];
  logic [4:0] m[26];
  int m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : rsp_mon
    logic [1:0] e;
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_code", 32'(rsp_code), 32'(e));
        check("rsp_err", 32'(rsp_err), 32'(e != RC_OK));
      end
    end
  end

  function automatic logic [1:0] model_code(input logic [1:0] op, input logic [4:0] a,
                                            input logic [4:0] b);
    if (op == OP_PAIR) begin
      if (a > 25 || b > 25 || a == b) return RC_BAD;
      if (m[a] != a || m[b] != b)     return RC_CONFLICT;
      if (m_cnt == 10)                return RC_FULL;
      return RC_OK;
    end
    if (op == OP_UNPAIR) begin
      if (a > 25)    return RC_BAD;
      if (m[a] == a) return RC_CONFLICT;
      return RC_OK;
    end
    return RC_OK;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 26; i++) m[i] = 5'(i);
    m_cnt = 0;
  endtask

  task automatic model_apply(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b);
    logic [4:0] p;
    case (op)
      OP_PAIR:   begin m[a] = b; m[b] = a; m_cnt++; end
      OP_UNPAIR: begin p = m[a]; m[a] = a; m[p] = p; m_cnt--; end
      OP_CLEAR:  model_reset();
      default: ;
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                       input logic [1:0] code);
    int w = 0;
    while (!cmd_ready && w < 100) begin @(posedge clk); #1; w++; end
    check("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    exp_q.push_back(code);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom_range(0, 3));
    cmd_a  = 5'($urandom_range(0, 31));
    cmd_b  = 5'($urandom_range(0, 31));
    check("busy_after_hs", {30'd0, cmd_ready, cfg_stable}, 32'd0);
  endtask

  task automatic wait_rsp(input int exp_lat, input int exp_low);
    int n = 0;
    int low = 0;
    while (!rsp_valid && n < 40) begin
      if (!cfg_stable) low++;
      @(posedge clk); #1; n++;
    end
    if (!cfg_stable) low++;
    check("rsp_latency", 32'(n), 32'(exp_lat));
    @(posedge clk); #1;
    check("ready_back", {30'd0, cmd_ready, cfg_stable}, 32'd3);
    check("rsp_pulse_len", 32'(rsp_valid), 32'd0);
    check("stable_low_cycles", 32'(low), 32'(exp_low));
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                        input logic [1:0] code);
    issue(op, a, b, code);
    wait_rsp(op == OP_CLEAR ? 26 : 1, op == OP_CLEAR ? 27 : 2);
    if (code == RC_OK) model_apply(op, a, b);
    check("pair_count", 32'(pair_count), 32'(m_cnt));
  endtask

  task automatic check_table();
    for (int k = 0; k < 26; k++) begin
      sig_in = 26'd1 << k;
      #1;
      check($sformatf("sig_%0d", k), 32'(sig_out), 32'(26'd1 << m[k]));
    end
    sig_in = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] op;
    logic [4:0] a, b;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; sig_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_stable", 32'(cfg_stable), 32'd1);
    check("rst_count", 32'(pair_count), 32'd0);
    check("rst_rsp", {29'd0, rsp_valid, rsp_code}, 32'd0);
    check_table();

    // First pair A<->B
    do_cmd(OP_PAIR, 5'd0, 5'd1, RC_OK);
    sig_in = 26'h1; #1; check("ab_a", 32'(sig_out), 32'h2);
    sig_in = 26'h2; #1; check("ab_b", 32'(sig_out), 32'h1);
    sig_in = '0;

    // Error cases leave the table untouched
    do_cmd(OP_PAIR, 5'd1, 5'd5, RC_CONFLICT);
    do_cmd(OP_PAIR, 5'd3, 5'd3, RC_BAD);
    do_cmd(OP_PAIR, 5'd26, 5'd2, RC_BAD);
    do_cmd(OP_UNPAIR, 5'd7, 5'd0, RC_CONFLICT);
    do_cmd(OP_UNPAIR, 5'd27, 5'd0, RC_BAD);
    do_cmd(OP_NOP, 5'd4, 5'd9, RC_OK);
    check_table();

    // Fill to capacity, then overflow
    for (int k = 1; k < 10; k++) do_cmd(OP_PAIR, 5'(2 * k), 5'(2 * k + 1), RC_OK);
    check("full_count", 32'(pair_count), 32'd10);
    do_cmd(OP_PAIR, 5'd20, 5'd21, RC_FULL);
    do_cmd(OP_UNPAIR, 5'd1, 5'd0, RC_OK);
    check("after_unpair_count", 32'(pair_count), 32'd9);
    check_table();

    // CLEAR with five pairs active
    for (int k = 1; k < 5; k++) do_cmd(OP_UNPAIR, 5'(2 * k + 1), 5'd0, RC_OK);
    check("pre_clear_count", 32'(pair_count), 32'd5);
    do_cmd(OP_CLEAR, 5'd0, 5'd0, RC_OK);
    check_table();

    // Random PAIR/UNPAIR traffic against the model
    for (int r = 0; r < 14; r++) begin
      op = 2'($urandom_range(1, 2));
      a  = 5'($urandom_range(0, 27));
      b  = 5'($urandom_range(0, 27));
      do_cmd(op, a, b, model_code(op, a, b));
    end
    check_table();

    // Reset in the middle of a CLEAR
    do_cmd(OP_CLEAR, 5'd0, 5'd0, RC_OK);
    do_cmd(OP_PAIR, 5'd2, 5'd3, RC_OK);
    do_cmd(OP_PAIR, 5'd20, 5'd21, RC_OK);
    issue(OP_CLEAR, 5'd0, 5'd0, RC_OK);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    check("midclr_ready", 32'(cmd_ready), 32'd1);
    check("midclr_stable", 32'(cfg_stable), 32'd1);
    check("midclr_count", 32'(pair_count), 32'd0);
    check("midclr_rsp", {29'd0, rsp_valid, rsp_code}, 32'd0);
    check_table();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (35) @(posedge clk);
    #1;
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    check_table();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety bound on total run time
  initial begin
    #2000000;
    $display("FAIL timeout sim did not finish");
    $fatal(1, "timeout");
  end

endmodule
